// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for a single-bus CPU datapath. It steps through
//   IDLE -> fetch (T0..T2) -> execute (T3..T7), with optional memory wait
//   states (RWAIT, WWAIT), a single-step PAUSE state and a terminal HALT.
//   Every output is registered. The outputs for a state are computed from the
//   next state, and the outputs are loaded on the same edge that enters that
//   state. As a result, each control is high for exactly the cycles spent in
//   its state.
//
// Ports
//   Clock      rising-edge clock
//   clear      asynchronous active-high reset (to IDLE, all outputs 0)
//   start      leave IDLE and begin fetching
//   step_mode  single-step enable, sampled only at instruction boundaries
//   step_req   permits one instruction while in single-step mode
//   ir_op      IR[31:27], latched at the end of T2
//   con_ff     branch condition, sampled on the edge that enters brx T6
//   drv[8:0]   PCout Zlowout Zhighout MDRout Rout BAout Cout HIout LOout
//   ld[9:0]    PCin MARin MDRin IRin Yin Zin Rin CONin HIin LOin
//   sel[2:0]   Gra Grb Grc
//   mem[2:0]   Read Write IncPC
//   alu_op     ALU operation, non-zero only together with Zin
//   run        high in every state except IDLE and HALT
//   step       state index (0..7 Tn, 8 RWAIT, 9 WWAIT, 13 PAUSE, 14 HALT, 15 IDLE)
//   illegal    one-cycle pulse in T3 of an undefined opcode
module control_sequencer #(
    parameter int RD_WAIT = 0,
    parameter int WR_WAIT = 0
) (
    input  logic       Clock,
    input  logic       clear,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step_req,
    input  logic [4:0] ir_op,
    input  logic       con_ff,
    output logic [8:0] drv,
    output logic [9:0] ld,
    output logic [2:0] sel,
    output logic [2:0] mem,
    output logic [4:0] alu_op,
    output logic       run,
    output logic [3:0] step,
    output logic       illegal
);

    // The state encoding equals the reported step index.
    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
        T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
        RWAIT = 4'd8, WWAIT = 4'd9,
        PAUSE = 4'd13, HALT = 4'd14, IDLE = 4'd15
    } state_t;

    typedef struct packed {
        logic       run;
        logic [3:0] step;
        logic       illegal;
        logic [4:0] alu_op;
        logic [2:0] mem;
        logic [2:0] sel;
        logic [9:0] ld;
        logic [8:0] drv;
    } ctl_t;

    // Bus driver bits
    localparam int PCOUT = 0, ZLOOUT = 1, MDROUT = 3, ROUT = 4, BAOUT = 5, COUT = 6;
    // Register load bits
    localparam int PCIN = 0, MARIN = 1, MDRIN = 2, IRIN = 3, YIN = 4, ZIN = 5, RIN = 6, CONIN = 7;
    // Register select and memory bits
    localparam int GRA = 0, GRB = 1, GRC = 2;
    localparam int READ = 0, WRITE = 1, INCPC = 2;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_ST  = 5'b00010, OP_ADD = 5'b00011,
                           OP_SUB  = 5'b00100, OP_AND = 5'b00101, OP_OR  = 5'b00110,
                           OP_ADDI = 5'b01100, OP_BRX = 5'b10011, OP_JR  = 5'b10100,
                           OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

    localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
    localparam logic [2:0] WR_CNT = 3'(WR_WAIT);

    state_t     state, state_n, t0_entry;
    logic [4:0] op, op_n;
    logic [2:0] cnt, cnt_n;
    logic       rd_late, late_n;   // 1: the RWAIT belongs to ld T6, so return to T7
    ctl_t       ctl;

    function automatic logic is_alu(input logic [4:0] o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) || (o == OP_OR);
    endfunction

    function automatic logic is_mem(input logic [4:0] o);
        return (o == OP_LD) || (o == OP_ST);
    endfunction

    // Controls for a given state. The opcode input only matters from T3 on.
    function automatic ctl_t decode(input state_t s, input logic [4:0] o, input logic cf);
        ctl_t c;
        c      = '0;
        c.step = s;
        c.run  = (s != IDLE) && (s != HALT);
        case (s)
            T0: begin
                c.drv[PCOUT] = 1'b1; c.ld[MARIN] = 1'b1; c.mem[INCPC] = 1'b1;
                c.ld[ZIN] = 1'b1; c.alu_op = OP_ADD;
            end
            T1: begin
                c.drv[ZLOOUT] = 1'b1; c.ld[PCIN] = 1'b1;
                c.mem[READ] = 1'b1; c.ld[MDRIN] = 1'b1;
            end
            RWAIT: begin
                c.mem[READ] = 1'b1; c.ld[MDRIN] = 1'b1;
            end
            T2: begin
                c.drv[MDROUT] = 1'b1; c.ld[IRIN] = 1'b1;
            end
            T3: begin
                if (is_alu(o) || o == OP_ADDI) begin
                    c.sel[GRB] = 1'b1; c.drv[ROUT] = 1'b1; c.ld[YIN] = 1'b1;
                end else if (is_mem(o)) begin
                    c.sel[GRB] = 1'b1; c.drv[BAOUT] = 1'b1; c.ld[YIN] = 1'b1;
                end else if (o == OP_JR) begin
                    c.sel[GRA] = 1'b1; c.drv[ROUT] = 1'b1; c.ld[PCIN] = 1'b1;
                end else if (o == OP_BRX) begin
                    c.sel[GRA] = 1'b1; c.drv[ROUT] = 1'b1; c.ld[CONIN] = 1'b1;
                end else if (o != OP_NOP && o != OP_HALT) begin
                    c.illegal = 1'b1;
                end
            end
            T4: begin
                if (is_alu(o)) begin
                    c.sel[GRC] = 1'b1; c.drv[ROUT] = 1'b1; c.ld[ZIN] = 1'b1; c.alu_op = o;
                end else if (o == OP_ADDI || is_mem(o)) begin
                    c.drv[COUT] = 1'b1; c.ld[ZIN] = 1'b1; c.alu_op = OP_ADD;
                end else if (o == OP_BRX) begin
                    c.drv[PCOUT] = 1'b1; c.ld[YIN] = 1'b1;
                end
            end
            T5: begin
                if (is_alu(o) || o == OP_ADDI) begin
                    c.drv[ZLOOUT] = 1'b1; c.sel[GRA] = 1'b1; c.ld[RIN] = 1'b1;
                end else if (is_mem(o)) begin
                    c.drv[ZLOOUT] = 1'b1; c.ld[MARIN] = 1'b1;
                end else if (o == OP_BRX) begin
                    c.drv[COUT] = 1'b1; c.ld[ZIN] = 1'b1; c.alu_op = OP_ADD;
                end
            end
            T6: begin
                if (o == OP_BRX) begin
                    c.drv[ZLOOUT] = 1'b1; c.ld[PCIN] = cf;
                end else if (o == OP_LD) begin
                    c.mem[READ] = 1'b1; c.ld[MDRIN] = 1'b1;
                end else if (o == OP_ST) begin
                    c.sel[GRA] = 1'b1; c.drv[ROUT] = 1'b1; c.ld[MDRIN] = 1'b1;
                end
            end
            T7: begin
                if (o == OP_LD) begin
                    c.drv[MDROUT] = 1'b1; c.sel[GRA] = 1'b1; c.ld[RIN] = 1'b1;
                end else if (o == OP_ST) begin
                    c.mem[WRITE] = 1'b1;
                end
            end
            WWAIT: c.mem[WRITE] = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Next state. Every path back to T0 goes through t0_entry, so step_mode
    // is only acted on at instruction boundaries.
    always_comb begin
        state_n  = state;
        op_n     = op;
        cnt_n    = cnt;
        late_n   = rd_late;
        t0_entry = (step_mode && !step_req) ? PAUSE : T0;
        case (state)
            IDLE:  if (start) state_n = t0_entry;
            PAUSE: if (step_req || !step_mode) state_n = T0;
            HALT:  state_n = HALT;
            T0:    state_n = T1;
            T1: begin
                if (RD_CNT != 3'd0) begin
                    state_n = RWAIT; cnt_n = RD_CNT; late_n = 1'b0;
                end else begin
                    state_n = T2;
                end
            end
            RWAIT: begin
                if (cnt <= 3'd1) begin
                    cnt_n   = 3'd0;
                    state_n = rd_late ? T7 : T2;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            T2: begin
                op_n    = ir_op;
                state_n = T3;
            end
            T3: begin
                if (op == OP_HALT)
                    state_n = HALT;
                else if (is_alu(op) || is_mem(op) || op == OP_ADDI || op == OP_BRX)
                    state_n = T4;
                else
                    state_n = t0_entry;
            end
            T4: state_n = T5;
            T5: state_n = (is_alu(op) || op == OP_ADDI) ? t0_entry : T6;
            T6: begin
                if (op == OP_LD && RD_CNT != 3'd0) begin
                    state_n = RWAIT; cnt_n = RD_CNT; late_n = 1'b1;
                end else if (op == OP_BRX) begin
                    state_n = t0_entry;
                end else begin
                    state_n = T7;
                end
            end
            T7: begin
                if (op == OP_ST && WR_CNT != 3'd0) begin
                    state_n = WWAIT; cnt_n = WR_CNT;
                end else begin
                    state_n = t0_entry;
                end
            end
            WWAIT: begin
                if (cnt <= 3'd1) begin
                    cnt_n   = 3'd0;
                    state_n = t0_entry;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            op      <= 5'd0;
            cnt     <= 3'd0;
            rd_late <= 1'b0;
        end else begin
            state   <= state_n;
            op      <= op_n;
            cnt     <= cnt_n;
            rd_late <= late_n;
        end
    end

    // Registered outputs. They are decoded from the state being entered.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            ctl      <= '0;
            ctl.step <= 4'hF;
        end else begin
            ctl <= decode(state_n, op_n, con_ff);
        end
    end

    assign drv     = ctl.drv;
    assign ld      = ctl.ld;
    assign sel     = ctl.sel;
    assign mem     = ctl.mem;
    assign alu_op  = ctl.alu_op;
    assign run     = ctl.run;
    assign step    = ctl.step;
    assign illegal = ctl.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Two instances run on the same stimulus:
// dut0 has no wait states, and dut1 has RD_WAIT=2 and WR_WAIT=3. A
// queue-based model expands each instruction into its list of per-cycle
// control words. Every cycle, each DUT output is compared against the model.
// Directed sequences also check literal step sequences and control counts.
module tb_control_sequencer;

    logic       Clock = 1'b0, clear = 1'b1, start = 1'b0;
    logic       step_mode = 1'b0, step_req = 1'b0, con_ff = 1'b0;
    logic [4:0] ir_op = 5'b11010;

    logic [8:0] drv[2];
    logic [9:0] ld[2];
    logic [2:0] sel[2], mem[2];
    logic [4:0] alu_op[2];
    logic       run[2], illegal[2];
    logic [3:0] step[2];

    control_sequencer #(.RD_WAIT(0), .WR_WAIT(0)) dut0 (
        .Clock(Clock), .clear(clear), .start(start), .step_mode(step_mode),
        .step_req(step_req), .ir_op(ir_op), .con_ff(con_ff),
        .drv(drv[0]), .ld(ld[0]), .sel(sel[0]), .mem(mem[0]), .alu_op(alu_op[0]),
        .run(run[0]), .step(step[0]), .illegal(illegal[0]));

    control_sequencer #(.RD_WAIT(2), .WR_WAIT(3)) dut1 (
        .Clock(Clock), .clear(clear), .start(start), .step_mode(step_mode),
        .step_req(step_req), .ir_op(ir_op), .con_ff(con_ff),
        .drv(drv[1]), .ld(ld[1]), .sel(sel[1]), .mem(mem[1]), .alu_op(alu_op[1]),
        .run(run[1]), .step(step[1]), .illegal(illegal[1]));

    always #5 Clock = ~Clock;

    int nvec = 0, nmis = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] step;
        logic [8:0] drv;
        logic [9:0] ld;
        logic [2:0] sel;
        logic [2:0] mem;
        logic [4:0] alu;
        logic       ill;
        logic       cond;   // brx T6: PCin follows con_ff
    } rec_t;

    localparam int M_IDLE = 0, M_PAUSE = 1, M_HALT = 2, M_RUN = 3;
    int         rdw[2] = '{0, 2};
    int         wrw[2] = '{0, 3};
    rec_t       mq[2][$];
    rec_t       cur[2];
    int         mode[2] = '{M_IDLE, M_IDLE};
    logic [4:0] mop[2];

    function automatic rec_t mk(input logic [3:0] s, input logic [8:0] d, input logic [9:0] l,
                                input logic [2:0] g, input logic [2:0] m, input logic [4:0] a);
        rec_t r;
        r.step = s; r.drv = d; r.ld = l; r.sel = g; r.mem = m; r.alu = a;
        r.ill = 1'b0; r.cond = 1'b0;
        return r;
    endfunction

    task automatic take(input int k);
        cur[k] = mq[k].pop_front();
        if (cur[k].cond) begin
            cur[k].ld[0] = con_ff;
            cur[k].cond  = 1'b0;
        end
    endtask

    task automatic begin_instr(input int k);
        mode[k] = M_RUN;
        mq[k].delete();
        mq[k].push_back(mk(0, 9'h001, 10'h022, 3'h0, 3'h4, 5'd3));
        mq[k].push_back(mk(1, 9'h002, 10'h005, 3'h0, 3'h1, 5'd0));
        for (int i = 0; i < rdw[k]; i++) mq[k].push_back(mk(8, 9'h000, 10'h004, 3'h0, 3'h1, 5'd0));
        mq[k].push_back(mk(2, 9'h008, 10'h008, 3'h0, 3'h0, 5'd0));
        take(k);
    endtask

    task automatic boundary(input int k);
        if (step_mode && !step_req) begin
            mode[k] = M_PAUSE;
            mq[k].delete();
            cur[k] = mk(13, 0, 0, 0, 0, 0);
        end else begin
            begin_instr(k);
        end
    endtask

    task automatic build_exec(input int k, input logic [4:0] o);
        rec_t r;
        case (o)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                mq[k].push_back(mk(3, 9'h010, 10'h010, 3'h2, 3'h0, 5'd0));
                mq[k].push_back(mk(4, 9'h010, 10'h020, 3'h4, 3'h0, o));
                mq[k].push_back(mk(5, 9'h002, 10'h040, 3'h1, 3'h0, 5'd0));
            end
            5'd12: begin
                mq[k].push_back(mk(3, 9'h010, 10'h010, 3'h2, 3'h0, 5'd0));
                mq[k].push_back(mk(4, 9'h040, 10'h020, 3'h0, 3'h0, 5'd3));
                mq[k].push_back(mk(5, 9'h002, 10'h040, 3'h1, 3'h0, 5'd0));
            end
            5'd0, 5'd2: begin
                mq[k].push_back(mk(3, 9'h020, 10'h010, 3'h2, 3'h0, 5'd0));
                mq[k].push_back(mk(4, 9'h040, 10'h020, 3'h0, 3'h0, 5'd3));
                mq[k].push_back(mk(5, 9'h002, 10'h002, 3'h0, 3'h0, 5'd0));
                if (o == 5'd0) begin
                    mq[k].push_back(mk(6, 9'h000, 10'h004, 3'h0, 3'h1, 5'd0));
                    for (int i = 0; i < rdw[k]; i++) mq[k].push_back(mk(8, 9'h000, 10'h004, 3'h0, 3'h1, 5'd0));
                    mq[k].push_back(mk(7, 9'h008, 10'h040, 3'h1, 3'h0, 5'd0));
                end else begin
                    mq[k].push_back(mk(6, 9'h010, 10'h004, 3'h1, 3'h0, 5'd0));
                    mq[k].push_back(mk(7, 9'h000, 10'h000, 3'h0, 3'h2, 5'd0));
                    for (int i = 0; i < wrw[k]; i++) mq[k].push_back(mk(9, 9'h000, 10'h000, 3'h0, 3'h2, 5'd0));
                end
            end
            5'd20: mq[k].push_back(mk(3, 9'h010, 10'h001, 3'h1, 3'h0, 5'd0));
            5'd19: begin
                mq[k].push_back(mk(3, 9'h010, 10'h080, 3'h1, 3'h0, 5'd0));
                mq[k].push_back(mk(4, 9'h001, 10'h010, 3'h0, 3'h0, 5'd0));
                mq[k].push_back(mk(5, 9'h040, 10'h020, 3'h0, 3'h0, 5'd3));
                r = mk(6, 9'h002, 10'h000, 3'h0, 3'h0, 5'd0);
                r.cond = 1'b1;
                mq[k].push_back(r);
            end
            5'd26, 5'd27: mq[k].push_back(mk(3, 0, 0, 0, 0, 0));
            default: begin
                r = mk(3, 0, 0, 0, 0, 0);
                r.ill = 1'b1;
                mq[k].push_back(r);
            end
        endcase
    endtask

    task automatic model_step(input int k);
        if (clear) begin
            mode[k] = M_IDLE;
            mq[k].delete();
            cur[k] = mk(15, 0, 0, 0, 0, 0);
        end else begin
            case (mode[k])
                M_IDLE:  if (start) boundary(k);
                M_PAUSE: if (step_req || !step_mode) begin_instr(k);
                M_HALT:  ;
                default: begin
                    if (mq[k].size() != 0) begin
                        take(k);
                    end else if (cur[k].step == 4'd2) begin
                        mop[k] = ir_op;
                        build_exec(k, ir_op);
                        take(k);
                    end else if (mop[k] == 5'd27) begin
                        mode[k] = M_HALT;
                        cur[k] = mk(14, 0, 0, 0, 0, 0);
                    end else begin
                        boundary(k);
                    end
                end
            endcase
        end
    endtask

    function automatic logic [35:0] expv(input int k);
        logic r;
        r = (mode[k] == M_RUN) || (mode[k] == M_PAUSE);
        return {r, cur[k].step, cur[k].ill, cur[k].alu, cur[k].mem, cur[k].sel, cur[k].ld, cur[k].drv};
    endfunction

    // Field layout: drv[8:0] ld[18:9] sel[21:19] mem[24:22] alu[29:25] ill[30] step[34:31] run[35]
    function automatic logic [35:0] actv(input int k);
        return {run[k], step[k], illegal[k], alu_op[k], mem[k], sel[k], ld[k], drv[k]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model advance on each rising edge; compare on the falling edge.
    initial begin
        cur[0] = mk(15, 0, 0, 0, 0, 0);
        cur[1] = mk(15, 0, 0, 0, 0, 0);
        forever begin
            @(posedge Clock);
            model_step(0);
            model_step(1);
            @(negedge Clock);
            for (int k = 0; k < 2; k++)
                check($sformatf("dut%0d cycle @%0t", k, $time), {28'h0, actv(k)}, {28'h0, expv(k)});
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [35:0] sv[40];
    int          es[$];

    task automatic sample(input int k, input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            @(negedge Clock);
            sv[i] = actv(k);
            start = 1'b0;
            step_req = 1'b0;
        end
    endtask

    task automatic chk_steps(input string nm);
        for (int i = 0; i < es.size(); i++)
            check($sformatf("%s step[%0d]", nm, i), {60'h0, sv[i][34:31]}, 64'(es[i]));
    endtask

    // Async clear mid-cycle: outputs must collapse at once, without waiting for a clock edge.
    task automatic do_clear();
        #2 clear = 1'b1;
        #1;
        check("clear_async dut0", {28'h0, actv(0)}, {28'h0, 1'b0, 4'hF, 31'h0});
        check("clear_async dut1", {28'h0, actv(1)}, {28'h0, 1'b0, 4'hF, 31'h0});
        @(negedge Clock);
        clear = 1'b0;
    endtask

    initial begin
        logic [35:0] v;
        int          cnt;
        logic [4:0]  legal[10] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd19, 5'd20, 5'd26};

        repeat (2) @(negedge Clock);
        clear = 1'b0;
        check("reset dut0", {28'h0, actv(0)}, {28'h0, 1'b0, 4'hF, 31'h0});
        check("reset dut1", {28'h0, actv(1)}, {28'h0, 1'b0, 4'hF, 31'h0});
        repeat (3) @(negedge Clock);
        v = actv(1);
        check("idle_hold", {59'h0, v[35:31]}, 64'h0F);

        // jr, no wait states: T0..T3 then T0 again
        start = 1'b1; ir_op = 5'b10100;
        sample(0, 0, 5);
        es = '{0, 1, 2, 3, 0};
        chk_steps("jr");
        check("jr T3 Gra/Rout/PCin", {61'h0, sv[3][19], sv[3][4], sv[3][9]}, 64'h7);
        do_clear();

        // add with RD_WAIT=2
        start = 1'b1; ir_op = 5'b00011;
        sample(1, 0, 9);
        es = '{0, 1, 8, 8, 2, 3, 4, 5, 0};
        chk_steps("add");
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(sv[i][22]);
        check("add read cycles", 64'(cnt), 64'd3);
        check("add T4 alu_op", {59'h0, sv[6][29:25]}, 64'h03);
        check("add T4 Grc/Rout/Zin", {61'h0, sv[6][21], sv[6][4], sv[6][14]}, 64'h7);
        do_clear();

        // st with WR_WAIT=3
        start = 1'b1; ir_op = 5'b00010;
        sample(1, 0, 14);
        es = '{0, 1, 8, 8, 2, 3, 4, 5, 6, 7, 9, 9, 9, 0};
        chk_steps("st");
        cnt = 0;
        for (int i = 0; i < 14; i++) cnt += int'(sv[i][23]);
        check("st write cycles", 64'(cnt), 64'd4);
        do_clear();

        // brx not taken, then taken
        con_ff = 1'b0; start = 1'b1; ir_op = 5'b10011;
        sample(0, 0, 7);
        con_ff = 1'b1;
        sample(0, 7, 7);
        es = '{0, 1, 2, 3, 4, 5, 6, 0, 1, 2, 3, 4, 5, 6};
        chk_steps("brx");
        check("brx T6 PCin con0", {63'h0, sv[6][9]}, 64'h0);
        check("brx T6 PCin con1", {63'h0, sv[13][9]}, 64'h1);
        cnt = 0;
        for (int i = 0; i < 14; i++) cnt += int'(sv[i][16]);
        check("brx CONin count", 64'(cnt), 64'd2);
        check("brx CONin T3", {63'h0, sv[3][16]}, 64'h1);
        do_clear();
        con_ff = 1'b0;

        // single step with an illegal opcode
        step_mode = 1'b1; ir_op = 5'b11111; start = 1'b1;
        sample(0, 0, 3);
        step_req = 1'b1;
        sample(0, 3, 5);
        es = '{13, 13, 13, 0, 1, 2, 3, 13};
        chk_steps("step");
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(sv[i][30]);
        check("illegal pulses", 64'(cnt), 64'd1);

        // halt: leave PAUSE because step_mode drops, then stick in HALT
        step_mode = 1'b0; ir_op = 5'b11011;
        sample(0, 0, 5);
        es = '{0, 1, 2, 3, 14};
        chk_steps("halt");
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; step_req = 1'b1;
            @(negedge Clock);
            v = actv(0);
            check("halt hold run/step", {59'h0, v[35:31]}, 64'h0E);
        end
        start = 1'b0; step_req = 1'b0;
        do_clear();

        // clear in the middle of an RWAIT
        start = 1'b1; ir_op = 5'b00000;
        sample(1, 0, 3);
        es = '{0, 1, 8};
        chk_steps("ld rwait");
        do_clear();

        // random phase
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clock);
            clear = 1'b0;
            if ($urandom_range(199) == 0) begin
                #2 clear = 1'b1;
            end
            start    = ($urandom_range(3) == 0);
            step_req = ($urandom_range(5) == 0);
            con_ff   = 1'($urandom_range(1));
            if ($urandom_range(39) == 0) step_mode = ~step_mode;
            case ($urandom_range(13))
                10: ir_op = ($urandom_range(3) == 0) ? 5'd27 : 5'd26;
                11, 12, 13: ir_op = 5'($urandom_range(31));
                default: ir_op = legal[$urandom_range(9)];
            endcase
        end
        @(negedge Clock);
        clear = 1'b0;
        @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
